fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and instruction-register stage of the multicycle MIPS core. Executes the PC/IR write commands issued by the control FSM (`ir_we`, `pc_we`, `pc_src`), runs a req/valid handshake with instruction memory, and presents the latched instruction back to the FSM. It also provides `pc_plus4` for JAL link writeback. While a fetch is outstanding it raises `fetch_busy`, and the FSM holds its state.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ir_we` in 1: fetch command from the FSM (IF state).
- `pc_we` in 2: 0 none, 1 unconditional, 2 write if `alu_zero`, 3 reserved.
- `pc_src` in 2: 0 PC+4, 1 `branch_target`, 2 `jr_target`, 3 jump (`{pc_plus4[31:28], ir[25:0], 2'b00}`).
- `alu_zero` in 1: ALU zero flag for BEQ.
- `branch_target` in 32: ALUOut (PC+4+offset<<2).
- `jr_target` in 32: rs read data.
- `imem_req` out 1: fetch request, held until accepted.
- `imem_addr` out 32: equals `pc` while `imem_req`.
- `imem_rdata` in 32: instruction word, valid with `imem_valid`.
- `imem_valid` in 1: memory response, sampled only in FETCH.
- `pc` out 32: current PC.
- `pc_plus4` out 32: `pc + 4`, combinational, modulo 2^32.
- `instruction` out 32: IR contents.
- `fetch_busy` out 1: high while state is FETCH.
- `fetch_done` out 1: one-cycle pulse on the cycle after IR loads.
- `err` out 1: sticky error flag, cleared only by reset.

## Operation
- States are IDLE and FETCH.
- **IDLE with `ir_we`=1:**
  - Capture `pc_we`/`pc_src` into a pending-update register.
  - Go to FETCH; `imem_req`=1 from the next cycle.
- **FETCH:**
  - On the edge where `imem_valid`=1: IR <= `imem_rdata`; apply the pending PC update using the pre-update `pc`/`pc_plus4`; return to IDLE; `fetch_done` <= 1.
  - `ir_we` and `pc_we` arriving during FETCH are ignored. A nonzero `pc_we` sets `err`.
- **IDLE with `ir_we`=0 and `pc_we`≠0:** PC is written on that edge.
  - `pc_we`=2 writes only if `alu_zero`=1.
  - `pc_we`=3 writes nothing and sets `err`.
- **Next-PC value:** selected by `pc_src`.
  - If the selected target has bits [1:0]≠0, write the target with bits [1:0] forced to 0 and set `err`.
- PC+4 wraps from 32'hFFFF_FFFC to 0 without flagging.
- **Reset values:** `pc`=`RESET_PC`, IR=0, IDLE, `imem_req`=0, `fetch_busy`=0, `fetch_done`=0, `err`=0, pending register=0.
- **Reset asserted mid-fetch:** the request is dropped immediately (asynchronous). A later `imem_valid` is ignored because the block is in IDLE.

## Timing
- `ir_we` high at edge N: `imem_req`/`fetch_busy` high after N.
- `imem_valid` high at edge N+k (k≥1): IR/PC update at N+k; `fetch_done` high for cycle N+k to N+k+1; `fetch_busy` low after N+k.
- Minimum fetch is 2 edges. Back-to-back fetches are possible: `ir_we` may be asserted in the `fetch_done` cycle.
- Non-fetch PC writes (JR, JAL, BEQ) take effect at the same edge they are sampled, with zero added latency.
- `imem_addr`, `imem_req`, `fetch_busy` and `fetch_done` are register outputs; only `pc_plus4` and the next-PC mux are combinational.

## Structure
- `fetch_pkg` holds:
  - enum `pc_src_t`: PC4, BRANCH, JR, JUMP.
  - enum `pc_we_t`: NONE, ALWAYS, IFZERO, RSVD.
  - enum `fetch_state_t`.
  - constant `INSN_BYTES`=4.
- The FSM's `pc_we`/`pc_src` encodings must import from `fetch_pkg`.
- Sub-module `pc_next_sel`: combinational next-PC mux plus alignment check. Outputs are the next PC and a misalign bit.

## Test plan
- **Reset and first fetch:** reset with `RESET_PC`=0; `ir_we`=1, `pc_we`=1, `pc_src`=0; `imem_valid` on the first FETCH cycle with rdata 32'h2405_0000 → IR=32'h2405_0000, `pc`=4, `fetch_done` 1 cycle, `err`=0.
- **Wait states:** `imem_valid` delayed 3 cycles → `fetch_busy` high 3 cycles, `imem_addr` stable at `pc`, PC unchanged until the valid edge.
- **BEQ:** `branch_target`=32'h40.
  - `pc_we`=2 with `alu_zero`=0 → `pc` unchanged.
  - `pc_we`=2 with `alu_zero`=1 → `pc`=32'h40.
- **JAL/JR:**
  - `pc`=32'h1000_0008, IR=32'h0C00_0010, `pc_src`=3 → `pc`=32'h1000_0040.
  - `jr_target`=32'h123 with `pc_src`=2 → `pc`=32'h120, `err`=1.
- **Misuse:**
  - `pc_we`=1 during FETCH → ignored, `err`=1.
  - `pc_we`=3 in IDLE → `pc` unchanged, `err`=1.
- **Reset mid-fetch:** `rst_n` low while `imem_req`=1 → `imem_req`=0 immediately, `pc`=`RESET_PC`; an `imem_valid` after release does not load IR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage of the multicycle core.
package fetch_pkg;

  // Next-PC source selected by the control FSM.
  typedef enum logic [1:0] {
    PC4    = 2'd0,
    BRANCH = 2'd1,
    JR     = 2'd2,
    JUMP   = 2'd3
  } pc_src_t;

  // PC write command issued by the control FSM.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    ALWAYS = 2'd1,
    IFZERO = 2'd2,
    RSVD   = 2'd3
  } pc_we_t;

  // Fetch handshake state.
  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  // PC update captured when a fetch starts and applied when it completes.
  typedef struct packed {
    pc_we_t  we;
    pc_src_t src;
  } pc_upd_t;

  localparam logic [31:0] INSN_BYTES = 32'd4;

  // True when an address is not word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC multiplexer with word-alignment check.
module pc_next_sel
  import fetch_pkg::*;
(
  input  pc_src_t     pc_src,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  input  logic [25:0] jump_index,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] target_s;

  // Select the raw target for the requested PC source.
  always_comb begin
    target_s = pc_plus4;
    case (pc_src)
      PC4:     target_s = pc_plus4;
      BRANCH:  target_s = branch_target;
      JR:      target_s = jr_target;
      JUMP:    target_s = {pc_plus4[31:28], jump_index, 2'b00};
      default: target_s = pc_plus4;
    endcase
  end

  // Force word alignment and report whether the target had to be fixed up.
  always_comb begin
    misalign = is_misaligned(target_s);
    next_pc  = {target_s[31:2], 2'b00};
  end

endmodule

// File: rtl/fetch_unit.sv
// PC and instruction register stage with imem req/valid handshake.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_we,
  input  logic [1:0]  pc_we,
  input  logic [1:0]  pc_src,
  input  logic        alu_zero,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instruction,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        err
);

  fetch_state_t state_r, state_s;
  pc_upd_t      pend_r, pend_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  ir_r, ir_s;
  logic         err_r, err_s;
  logic         done_r, done_s;

  logic [31:0]  pc_plus4_s;
  pc_we_t       act_we_s;
  pc_src_t      act_src_s;
  logic         upd_s;
  logic         do_write_s;
  logic         rsvd_s;
  logic [31:0]  tgt_s;
  logic         mis_s;

  assign pc_plus4_s = pc_r + INSN_BYTES;

  // During a fetch the captured command drives the update; otherwise the live one.
  always_comb begin
    if (state_r == FETCH) begin
      act_we_s  = pend_r.we;
      act_src_s = pend_r.src;
      upd_s     = imem_valid;
    end else begin
      act_we_s  = pc_we_t'(pc_we);
      act_src_s = pc_src_t'(pc_src);
      upd_s     = ~ir_we;
    end
  end

  // Decode whether the active PC command writes, and whether it is the reserved code.
  always_comb begin
    do_write_s = 1'b0;
    rsvd_s     = 1'b0;
    case (act_we_s)
      NONE:    do_write_s = 1'b0;
      ALWAYS:  do_write_s = 1'b1;
      IFZERO:  do_write_s = alu_zero;
      RSVD:    rsvd_s     = 1'b1;
      default: do_write_s = 1'b0;
    endcase
  end

  pc_next_sel u_pc_next_sel (
    .pc_src        (act_src_s),
    .pc_plus4      (pc_plus4_s),
    .branch_target (branch_target),
    .jr_target     (jr_target),
    .jump_index    (ir_r[25:0]),
    .next_pc       (tgt_s),
    .misalign      (mis_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state, pending-command capture and IR load.
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    ir_s    = ir_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (ir_we) begin
          state_s = FETCH;
          pend_s  = '{we: pc_we_t'(pc_we), src: pc_src_t'(pc_src)};
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (imem_valid) begin
          state_s = IDLE;
          ir_s    = imem_rdata;
          done_s  = 1'b1;
        end else begin
          state_s = FETCH;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // PC write and sticky error accumulation.
  always_comb begin
    if (upd_s && do_write_s) begin
      pc_s = tgt_s;
    end else begin
      pc_s = pc_r;
    end
    err_s = err_r
          | (upd_s & do_write_s & mis_s)
          | (upd_s & rsvd_s)
          | ((state_r == FETCH) & (pc_we != 2'd0));
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r   <= RESET_PC;
      ir_r   <= 32'h0000_0000;
      err_r  <= 1'b0;
      done_r <= 1'b0;
      pend_r <= '{we: NONE, src: PC4};
    end else begin
      pc_r   <= pc_s;
      ir_r   <= ir_s;
      err_r  <= err_s;
      done_r <= done_s;
      pend_r <= pend_s;
    end
  end

  assign imem_req    = (state_r == FETCH);
  assign fetch_busy  = (state_r == FETCH);
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_plus4_s;
  assign instruction = ir_r;
  assign fetch_done  = done_r;
  assign err         = err_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir_we = 1'b0;
  logic [1:0]  pc_we = 2'd0;
  logic [1:0]  pc_src = 2'd0;
  logic        alu_zero = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] jr_target = 32'h0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_valid = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instruction;
  logic        fetch_busy;
  logic        fetch_done;
  logic        err;

  int n_checks = 0;
  int n_fail = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_zero(alu_zero), .branch_target(branch_target), .jr_target(jr_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .pc(pc), .pc_plus4(pc_plus4),
    .instruction(instruction), .fetch_busy(fetch_busy),
    .fetch_done(fetch_done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ir = 32'h0;
  logic        m_err = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [1:0]  m_pwe = 2'd0;
  logic [1:0]  m_psrc = 2'd0;

  function automatic logic [31:0] target(input logic [1:0] src, input logic [31:0] cur_pc,
                                         input logic [31:0] ir);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    case (src)
      2'd0:    return seq;
      2'd1:    return branch_target;
      2'd2:    return jr_target;
      default: return (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
    endcase
  endfunction

  task automatic apply_cmd(input logic [1:0] we, input logic [1:0] src, input logic [31:0] ir);
    logic [31:0] t;
    logic        wr;
    wr = (we == 2'd1) || (we == 2'd2 && alu_zero);
    if (we == 2'd3) m_err = 1'b1;
    if (wr) begin
      t = target(src, m_pc, ir);
      if (t % 32'd4 != 32'd0) m_err = 1'b1;
      m_pc = t & 32'hFFFF_FFFC;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] old_ir;
    if (!rst_n) begin
      m_pc = 32'h0; m_ir = 32'h0; m_err = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_pwe = 2'd0; m_psrc = 2'd0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (pc_we != 2'd0) m_err = 1'b1;
        if (imem_valid) begin
          old_ir = m_ir;
          m_ir   = imem_rdata;
          m_busy = 1'b0;
          m_done = 1'b1;
          apply_cmd(m_pwe, m_psrc, old_ir);
        end
      end else if (ir_we) begin
        m_busy = 1'b1;
        m_pwe  = pc_we;
        m_psrc = pc_src;
      end else if (pc_we != 2'd0) begin
        apply_cmd(pc_we, pc_src, m_ir);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("m_pc", pc, m_pc);
    chk("m_pc4", pc_plus4, m_pc + 32'd4);
    chk("m_ir", instruction, m_ir);
    chk("m_err", {31'd0, err}, {31'd0, m_err});
    chk("m_busy", {31'd0, fetch_busy}, {31'd0, m_busy});
    chk("m_req", {31'd0, imem_req}, {31'd0, m_busy});
    chk("m_done", {31'd0, fetch_done}, {31'd0, m_done});
    if (imem_req) chk("m_addr", imem_addr, m_pc);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [1:0] we, input logic [1:0] src);
    ir_we = 1'b1; pc_we = we; pc_src = src;
    step();
    ir_we = 1'b0; pc_we = 2'd0;
  endtask

  task automatic deliver(input logic [31:0] word);
    imem_valid = 1'b1; imem_rdata = word;
    step();
    imem_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", instruction, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
    chk("rst_done", {31'd0, fetch_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    step();

    // First fetch, valid on first FETCH cycle
    start_fetch(2'd1, 2'd0);
    chk("f1_req", {31'd0, imem_req}, 32'd1);
    chk("f1_addr", imem_addr, 32'h0);
    deliver(32'h2405_0000);
    chk("f1_ir", instruction, 32'h2405_0000);
    chk("f1_pc", pc, 32'h4);
    chk("f1_done", {31'd0, fetch_done}, 32'd1);
    chk("f1_busy", {31'd0, fetch_busy}, 32'd0);
    chk("f1_err", {31'd0, err}, 32'd0);

    // Back-to-back fetch with three wait cycles
    start_fetch(2'd1, 2'd0);
    chk("f2_done_low", {31'd0, fetch_done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("f2_busy", {31'd0, fetch_busy}, 32'd1);
      chk("f2_addr", imem_addr, 32'h4);
      chk("f2_pc", pc, 32'h4);
      step();
    end
    deliver(32'h8C01_0004);
    chk("f2_pc_after", pc, 32'h8);
    chk("f2_ir", instruction, 32'h8C01_0004);
    step();
    chk("f2_done_drop", {31'd0, fetch_done}, 32'd0);

    // BEQ not taken then taken
    branch_target = 32'h40; pc_we = 2'd2; pc_src = 2'd1; alu_zero = 1'b0;
    step();
    chk("beq_nt", pc, 32'h8);
    alu_zero = 1'b1;
    step();
    chk("beq_t", pc, 32'h40);
    pc_we = 2'd0; alu_zero = 1'b0;

    // JAL: set pc then jump through the fetched instruction
    jr_target = 32'h1000_0004; pc_we = 2'd1; pc_src = 2'd2;
    step();
    pc_we = 2'd0;
    start_fetch(2'd1, 2'd0);
    deliver(32'h0C00_0010);
    chk("jal_pre_pc", pc, 32'h1000_0008);
    pc_we = 2'd1; pc_src = 2'd3;
    step();
    pc_we = 2'd0;
    chk("jal_pc", pc, 32'h1000_0040);
    chk("jal_err", {31'd0, err}, 32'd0);

    // Misaligned JR
    jr_target = 32'h0000_0123; pc_we = 2'd1; pc_src = 2'd2;
    step();
    pc_we = 2'd0;
    chk("jr_pc", pc, 32'h120);
    chk("jr_err", {31'd0, err}, 32'd1);

    // pc_we during FETCH is ignored but flagged
    do_reset();
    start_fetch(2'd1, 2'd0);
    branch_target = 32'h40; pc_we = 2'd1; pc_src = 2'd1;
    step();
    pc_we = 2'd0; pc_src = 2'd0;
    chk("mis_pc", pc, 32'h0);
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_busy", {31'd0, fetch_busy}, 32'd1);
    deliver(32'hAAAA_0000);
    chk("mis_pc_after", pc, 32'h4);

    // Reserved pc_we in IDLE
    do_reset();
    pc_we = 2'd3; pc_src = 2'd1;
    step();
    pc_we = 2'd0; pc_src = 2'd0;
    chk("rsvd_pc", pc, 32'h0);
    chk("rsvd_err", {31'd0, err}, 32'd1);

    // PC+4 wrap is silent
    do_reset();
    jr_target = 32'hFFFF_FFFC; pc_we = 2'd1; pc_src = 2'd2;
    step();
    chk("wrap_top", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    pc_src = 2'd0;
    step();
    pc_we = 2'd0;
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_err", {31'd0, err}, 32'd0);

    // Reset asserted mid-fetch
    jr_target = 32'h0000_0100; pc_we = 2'd1; pc_src = 2'd2;
    step();
    pc_we = 2'd0;
    start_fetch(2'd1, 2'd0);
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    chk("mid_addr", imem_addr, 32'h100);
    rst_n = 1'b0;
    #1;
    chk("mid_req_drop", {31'd0, imem_req}, 32'd0);
    chk("mid_pc_rst", pc, 32'h0);
    step();
    rst_n = 1'b1;
    deliver(32'hDEAD_BEEF);
    chk("mid_ir", instruction, 32'h0);
    chk("mid_done", {31'd0, fetch_done}, 32'd0);
    chk("mid_pc", pc, 32'h0);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
